// File: rtl/bcd_countdown_2digits.sv
// Two-digit BCD down counter with IDLE/RUN/PAUSE/EXPIRED control FSM.
// Counts a loaded value down to 00 on tick pulses and flags expiry with a
// one-cycle done pulse. AUTO_RELOAD=1 reloads the last loaded value instead.
module bcd_countdown_2digits #(
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_value,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] count,
  output logic       running,
  output logic       done,
  output logic       expired
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSE   = 2'd2,
    EXPIRED = 2'd3
  } state_t;

  state_t     state, state_next;
  logic [7:0] count_next;
  logic [7:0] reload_q, reload_next;
  logic       done_next;

  // Clamp each BCD digit to 9 so count always stays valid BCD.
  function automatic logic [7:0] sanitize_bcd(input logic [7:0] v);
    logic [3:0] tens, units;
    tens  = (v[7:4] > 4'd9) ? 4'd9 : v[7:4];
    units = (v[3:0] > 4'd9) ? 4'd9 : v[3:0];
    return {tens, units};
  endfunction

  // One BCD step down with borrow from tens; 00 holds (no wrap).
  function automatic logic [7:0] bcd_decrement(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'h00)
      r = 8'h00;
    else if (v[3:0] != 4'd0)
      r = {v[7:4], v[3:0] - 4'd1};
    else
      r = {v[7:4] - 4'd1, 4'd9};
    return r;
  endfunction

  // Next-state and next-data logic; priority load > pause > start > tick.
  always_comb begin
    state_next  = state;
    count_next  = count;
    reload_next = reload_q;
    done_next   = 1'b0;
    if (load) begin
      count_next  = sanitize_bcd(load_value);
      reload_next = sanitize_bcd(load_value);
      state_next  = IDLE;
    end else if (pause) begin
      // A pause request consumes the cycle, so start/tick alongside it are dropped.
      if (state == RUN)
        state_next = PAUSE;
    end else if (start) begin
      if ((state == IDLE || state == PAUSE) && count != 8'h00)
        state_next = RUN;
    end else if (tick && state == RUN) begin
      if (count == 8'h01) begin
        done_next = 1'b1;
        if (AUTO_RELOAD) begin
          count_next = reload_q;
        end else begin
          count_next = 8'h00;
          state_next = EXPIRED;
        end
      end else begin
        count_next = bcd_decrement(count);
      end
    end
  end

  // State, count, reload and done registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      count    <= 8'h00;
      reload_q <= 8'h00;
      done     <= 1'b0;
    end else begin
      state    <= state_next;
      count    <= count_next;
      reload_q <= reload_next;
      done     <= done_next;
    end
  end

  assign running = (state == RUN);
  assign expired = (state == EXPIRED);

endmodule

// File: tb/tb_bcd_countdown_2digits.sv
// Directed testbench for bcd_countdown_2digits: one instance with
// AUTO_RELOAD=0 and one with AUTO_RELOAD=1, both driven by shared inputs.
module tb_bcd_countdown_2digits;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_value = 8'h00;
  logic       start = 1'b0;
  logic       pause = 1'b0;

  logic [7:0] count0, count1;
  logic       running0, running1, done0, done1, expired0, expired1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bcd_countdown_2digits #(.AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .reset(reset), .tick(tick), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .count(count0), .running(running0),
    .done(done0), .expired(expired0)
  );

  bcd_countdown_2digits #(.AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .reset(reset), .tick(tick), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .count(count1), .running(running1),
    .done(done1), .expired(expired1)
  );

  // Advance one clock and sample 1 time unit after the rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(); reset = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1; load_value = v; cyc(); load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1; cyc(); start = 1'b0;
  endtask

  task automatic do_tick();
    tick = 1'b1; cyc(); tick = 1'b0;
  endtask

  function automatic logic [7:0] to_bcd(input int n);
    logic [3:0] t, u;
    t = 4'(n / 10);
    u = 4'(n % 10);
    return {t, u};
  endfunction

  logic [7:0] ar_exp [7];
  int done_pulses;

  initial begin
    ar_exp = '{8'h02, 8'h01, 8'h03, 8'h02, 8'h01, 8'h03, 8'h02};
    #1;

    // Reset state
    do_reset();
    chk("rst_count", count0, 8'h00);
    chk("rst_running", running0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_expired", expired0, 1'b0);

    // Load 25, start, 25 ticks spaced 3 clocks apart
    do_load(8'h25);
    chk("load25_count", count0, 8'h25);
    chk("load25_running", running0, 1'b0);
    do_start();
    chk("start_running", running0, 1'b1);
    for (int i = 1; i <= 25; i++) begin
      do_tick();
      chk($sformatf("cd_count_%0d", i), count0, to_bcd(25 - i));
      chk($sformatf("cd_done_%0d", i), done0, (i == 25) ? 8'h01 : 8'h00);
      cyc();
      chk($sformatf("cd_gap1_done_%0d", i), done0, 1'b0);
      cyc();
      chk($sformatf("cd_gap2_done_%0d", i), done0, 1'b0);
    end
    chk("exp_expired", expired0, 1'b1);
    chk("exp_running", running0, 1'b0);
    do_tick();
    chk("tick26_count", count0, 8'h00);
    chk("tick26_done", done0, 1'b0);
    chk("tick26_expired", expired0, 1'b1);

    // Sanitize on load, borrow across digits
    do_load(8'hAF);
    chk("loadAF_count", count0, 8'h99);
    chk("loadAF_expired", expired0, 1'b0);
    do_load(8'h10);
    do_start();
    do_tick();
    chk("borrow_count", count0, 8'h09);

    // Pause with simultaneous tick
    do_load(8'h42);
    do_start();
    pause = 1'b1; tick = 1'b1; cyc(); pause = 1'b0; tick = 1'b0;
    chk("pause_count", count0, 8'h42);
    chk("pause_running", running0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      do_tick();
      chk($sformatf("paused_tick_%0d", i), count0, 8'h42);
    end
    pause = 1'b1; start = 1'b1; cyc(); pause = 1'b0; start = 1'b0;
    chk("pause_start_running", running0, 1'b0);
    do_start();
    chk("resume_running", running0, 1'b1);
    do_tick();
    chk("resume_count", count0, 8'h41);

    // Load 00 then start stays IDLE
    do_load(8'h00);
    do_start();
    chk("zero_start_running", running0, 1'b0);
    chk("zero_start_done", done0, 1'b0);
    do_tick();
    chk("zero_tick_count", count0, 8'h00);
    chk("zero_tick_done", done0, 1'b0);

    // Reset together with tick and load while running
    do_load(8'h37);
    do_start();
    chk("r37_running", running0, 1'b1);
    reset = 1'b1; tick = 1'b1; load = 1'b1; load_value = 8'h55;
    cyc();
    reset = 1'b0; tick = 1'b0; load = 1'b0;
    chk("midrst_count", count0, 8'h00);
    chk("midrst_running", running0, 1'b0);
    chk("midrst_expired", expired0, 1'b0);
    chk("midrst_done", done0, 1'b0);

    // AUTO_RELOAD instance
    do_reset();
    do_load(8'h03);
    do_start();
    done_pulses = 0;
    for (int i = 0; i < 7; i++) begin
      do_tick();
      chk($sformatf("ar_count_%0d", i), count1, ar_exp[i]);
      chk($sformatf("ar_done_%0d", i), done1, (i == 2 || i == 5) ? 8'h01 : 8'h00);
      chk($sformatf("ar_running_%0d", i), running1, 1'b1);
      chk($sformatf("ar_expired_%0d", i), expired1, 1'b0);
      if (done1) done_pulses++;
      cyc();
      chk($sformatf("ar_gap_done_%0d", i), done1, 1'b0);
    end
    chk("ar_done_pulses", 8'(done_pulses), 8'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_2digits.md
Name: bcd_countdown_2digits

Overview:
- Two-digit BCD down counter with a control state machine. It counts from a loaded value down to 00, one step per tick pulse.
- It is the down-counting counterpart of the team's two-digit decade up counter, and serves as the countdown timer in the display/timing path.
- Outputs packed BCD {tens, units} for the 7-segment decoders.
- Flags expiry with a one-cycle done pulse and a level expired flag.

Parameters:
- AUTO_RELOAD, 0: 1 = on expiry, reload the last loaded value and keep running. 0 = stop at 00.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- tick  input  1  one-cycle count-enable pulse, e.g. a 1 Hz strobe; never used as a clock.
- load  input  1  load request.
- load_value  input  8  packed BCD value {tens[7:4], units[3:0]}.
- start  input  1  start/resume request.
- pause  input  1  pause request.
- count  output  8  current packed BCD value {tens, units}.
- running  output  1  high while in RUN.
- done  output  1  one-cycle pulse at expiry.
- expired  output  1  high while in EXPIRED.

Behaviour:
- Single clock domain. Reset is synchronous and active-high; it is sampled only on the rising edge of clk.
- All outputs are registered. Any input change appears on the outputs one clk cycle later.
- Reset values: count=8'h00, state=IDLE, running=0, done=0, expired=0, reload register=8'h00.
- States:
  - IDLE
  - RUN
  - PAUSE
  - EXPIRED (reachable only when AUTO_RELOAD=0)
- Input priority per cycle: reset > load > pause > start > tick.
- load (any state):
  - Each digit is sanitized first: a digit value >9 becomes 9.
  - count and the reload register take the sanitized value.
  - Next state is IDLE. done=0 and expired=0.
  - All other inputs are ignored that cycle.
- start:
  - In IDLE or PAUSE with count!=00: go to RUN.
  - In IDLE or PAUSE with count==00: ignored, stay in the current state.
  - In RUN or EXPIRED: ignored.
- pause:
  - In RUN: go to PAUSE. A tick in the same cycle is discarded and there is no decrement.
  - In other states: ignored.
  - pause together with start in PAUSE: stay in PAUSE.
- tick in RUN, BCD decrement:
  - units!=0: units = units-1.
  - units==0: units = 9 and tens = tens-1.
  - 10 -> 09, 01 -> 00.
  - count never wraps below 00.
- Expiry (tick in RUN while count==01):
  - AUTO_RELOAD=0: count becomes 00 and state becomes EXPIRED. done=1 for exactly that one cycle; expired=1 from that cycle until load or reset.
  - AUTO_RELOAD=1: count becomes the reload value, state stays RUN, done pulses for one cycle, expired stays 0.
- In IDLE, PAUSE and EXPIRED, tick is ignored and count holds.
- Output coding:
  - running = (state==RUN).
  - done = 0 except on the single expiry cycle.
- Reset mid-operation: reset on any cycle forces all reset values next cycle, regardless of the other inputs.
- Invariant: count always holds valid BCD (each digit 0..9).

Test Plan:
- Reset, load 8'h25, start, then 25 ticks spaced 3 clks apart:
  - count steps 25,24,...,20,19,...,01,00.
  - done is high for exactly one cycle, coincident with the first cycle of count==00.
  - expired=1 and running=0 afterwards.
  - A 26th tick leaves count at 00.
- Load 8'hAF: count=8'h99 next cycle. Load 8'h10, start, 1 tick: count=8'h09 (borrow across digits).
- Running at 8'h42, assert pause and tick in the same cycle:
  - count stays 42 and state is PAUSE, running=0.
  - 5 further ticks: no change.
  - start: running=1, and the next tick gives 41.
- Load 8'h00 then start: state stays IDLE, running=0, done never pulses.
- Running at 8'h37, assert reset together with tick and load: next cycle count=00, running=0, expired=0, done=0.
- AUTO_RELOAD=1, load 8'h03, start, 7 ticks:
  - count sequence 02,01,03,02,01,03,02.
  - done pulses twice.
  - expired stays 0 and running stays 1.
